// File: rtl/param_queue.sv
// ---------------------------------------------------------------------------
// param_queue
//
// Parametrised single-clock circular FIFO. Entries of WIDTH bits are written
// by a producer (insert) and popped by a consumer (read). Occupancy is kept
// in a separate counter so that full and empty are distinguishable even when
// the read and write pointers are equal.
//
// When the queue is full, an insert without a simultaneous read follows the
// full-policy parameter:
//   OVERWRITE=1 : the new entry replaces the oldest one.
//   OVERWRITE=0 : the new entry is dropped.
// Either way the sticky overflow flag is set. It clears only on rst or flush.
//
// Optional feature macro: PARAM_QUEUE_ALMOST_EN
//   When defined, this adds parameters ALMOST_FULL and ALMOST_EMPTY, and
//   registered outputs almost_full_o and almost_empty_o.
//
// Parameters:
//   WIDTH      entry width in bits
//   DEPTH      number of entries (power of two, >= 2)
//   OVERWRITE  full-policy select (1 = overwrite oldest, 0 = drop newest)
//
// Ports:
//   clk         system clock, rising-edge
//   rst         synchronous active-high reset
//   insert      write data_i this cycle
//   read        pop the oldest entry this cycle
//   flush       synchronous discard of all contents
//   data_i      entry to write
//   valid_o     one-cycle pulse: data_o holds a freshly popped entry
//   data_o      registered popped entry; holds its value between pops
//   full_o      count_o == DEPTH
//   empty_o     count_o == 0
//   count_o     current occupancy, 0..DEPTH
//   overflow_o  sticky: an insert arrived while full without a read
//   almost_full_o / almost_empty_o  (only with PARAM_QUEUE_ALMOST_EN)
// ---------------------------------------------------------------------------
module param_queue #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int OVERWRITE = 1
`ifdef PARAM_QUEUE_ALMOST_EN
    ,
    parameter int ALMOST_FULL  = DEPTH - 4,
    parameter int ALMOST_EMPTY = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     insert,
    input  logic                     read,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
`ifdef PARAM_QUEUE_ALMOST_EN
    ,
    output logic                     almost_full_o,
    output logic                     almost_empty_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef PARAM_QUEUE_ALMOST_EN
    localparam logic [CW-1:0] ALMOST_FULL_C  = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] ALMOST_EMPTY_C = CW'(ALMOST_EMPTY);
`endif

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
`ifdef PARAM_QUEUE_ALMOST_EN
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
`endif

    logic             is_full;
    logic             do_pop;
    logic             do_write;
    logic             do_drop;
    logic             overflow_evt;
    logic             mem_we;

    // Decode the cycle's operations and compute the next state. Flush
    // overrides insert and read. A read on an empty queue is ignored even
    // when an insert happens in the same cycle, because there is no bypass
    // path. When the queue is full, a simultaneous read frees the slot that
    // the insert then fills. The memory is read before it is written, so the
    // popped value is the old entry even though both pointers are equal.
    always_comb begin
        is_full      = (count_q == DEPTH_C);
        do_pop       = read && (count_q != '0) && !flush;
        do_write     = insert && !flush && (!is_full || read || (OVERWRITE != 0));
        do_drop      = insert && !flush && is_full && !read && (OVERWRITE != 0);
        overflow_evt = insert && !flush && is_full && !read;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop || do_drop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_pop) begin
                valid_d = 1'b1;
                data_d  = mem[rd_ptr_q];
            end
            if (do_write && !do_pop && !do_drop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_write) begin
                count_d = count_q - CW'(1);
            end
            if (overflow_evt) begin
                overflow_d = 1'b1;
            end
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
`ifdef PARAM_QUEUE_ALMOST_EN
        almost_full_d  = (count_d >= ALMOST_FULL_C);
        almost_empty_d = (count_d <= ALMOST_EMPTY_C);
`endif

        mem_we = do_write && !rst;
    end

    // Storage array. It is deliberately not reset, so it can map onto SRAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            valid_q        <= 1'b0;
            data_q         <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            overflow_q     <= 1'b0;
`ifdef PARAM_QUEUE_ALMOST_EN
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            data_q         <= data_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            overflow_q     <= overflow_d;
`ifdef PARAM_QUEUE_ALMOST_EN
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
`endif
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
`ifdef PARAM_QUEUE_ALMOST_EN
    assign almost_full_o  = almost_full_q;
    assign almost_empty_o = almost_empty_q;
`endif

endmodule

// File: doc/param_queue.md
Name: param_queue

Overview:
- Parametrised circular FIFO with a single clock, built on a register/SRAM array.
- Buffers WIDTH-bit entries between a producer (insert) and a consumer (read).
- Successor to the fixed 8-bit, 1024-entry queue. Adds:
  - selectable full-policy: overwrite-oldest or drop-newest
  - occupancy count and full/empty flags
  - sticky overflow flag
  - synchronous flush
- Sits between event producers and downstream consumers in the accelerator datapath.

Parameters:
- WIDTH, 8: entry width in bits.
- DEPTH, 1024: number of entries; must be a power of two and at least 2.
- OVERWRITE, 1: 1 = an insert when full replaces the oldest entry; 0 = an insert when full is dropped.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- insert  input  1  write data_i this cycle.
- read  input  1  pop the oldest entry this cycle.
- flush  input  1  discard all contents; synchronous.
- data_i  input  WIDTH  entry to write.
- valid_o  output  1  data_o holds a popped entry (one-cycle pulse per pop).
- data_o  output  WIDTH  popped entry (registered).
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  output  1  sticky; set when an insert arrives while full and no read occurs in the same cycle.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. Reset applies on a rising edge of clk with rst=1.
- Reset state:
  - wr_ptr=0, rd_ptr=0, count_o=0
  - valid_o=0, data_o=0
  - empty_o=1, full_o=0, overflow_o=0
  - Array contents are not cleared.
  - A reset asserted mid-stream discards everything in flight; valid_o goes low on the next edge.
- Priority in a cycle: rst > flush > insert/read.
- Flush:
  - Sets pointers and count to 0 and clears overflow_o and valid_o.
  - Any insert or read in the same cycle is ignored.
- Pointers: log2(DEPTH) bits each, wrap modulo DEPTH naturally. Count is tracked separately so that full and empty are distinguishable.
- Read latency:
  - A read on edge N with count>0 drives data_o = mem[rd_ptr] and valid_o=1 after edge N; rd_ptr increments.
  - Back-to-back reads stream one entry per cycle.
  - With no successful read, valid_o=0 and data_o holds its last value.
- Read when empty: ignored. valid_o=0; pointers and count are unchanged.
- Insert when not full: mem[wr_ptr] <= data_i, wr_ptr increments, count increments.
- Insert and read together:
  - 0 < count < DEPTH: both occur; count is unchanged.
  - count == 0: the insert occurs and the read is ignored (no bypass). valid_o=0, count becomes 1.
  - count == DEPTH: the read pops the oldest entry and the insert writes into the freed slot. count stays DEPTH; overflow_o is not set.
- Insert when full without a read:
  - OVERWRITE=1: mem[wr_ptr] <= data_i, and both wr_ptr and rd_ptr increment, so the oldest entry is lost. count stays DEPTH; overflow_o <= 1.
  - OVERWRITE=0: data is dropped; pointers and count are unchanged; overflow_o <= 1.
- Flags: full_o, empty_o and count_o are registered and consistent with the post-edge state. No combinational path from inputs to outputs.
- overflow_o remains set until rst or flush.

Optional Feature:
- Macro: PARAM_QUEUE_ALMOST_EN.
- When defined:
  - Adds parameter ALMOST_FULL (default DEPTH-4) and ALMOST_EMPTY (default 4).
  - Adds registered outputs almost_full_o (count_o >= ALMOST_FULL) and almost_empty_o (count_o <= ALMOST_EMPTY).
  - Reset values: almost_full_o=0, almost_empty_o=1.
  - Both outputs update on the same edge as count_o.
- When undefined: neither these ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=1 for one cycle, then data_i=8'hEC with insert=0 for one cycle.
  - Expect count_o=0, empty_o=1, valid_o=0 throughout.
- FIFO order: insert 8'h01, 8'h02, 8'h03 on consecutive cycles, then read for 3 cycles.
  - Expect valid_o=1 with data_o=01, 02, 03 on the cycles after each read edge.
  - Then count_o=0 and empty_o=1. A 4th read gives valid_o=0.
- Overwrite (DEPTH=1024, OVERWRITE=1): insert i[7:0] for i=0..1029, then read 1030 times.
  - Expect full_o=1 from insert 1024 onward and overflow_o=1 after insert 1025.
  - The first 1024 reads return (6..1029)[7:0]; the final 6 reads give valid_o=0.
- Drop policy (DEPTH=4, OVERWRITE=0): insert 0xA0..0xA5.
  - Expect count_o=4 and overflow_o=1; reads return A0, A1, A2, A3.
- Simultaneous edges (DEPTH=4):
  - When full, insert 0x55 and read together: data_o=oldest entry, count_o stays 4, overflow_o stays 0.
  - When empty, insert 0x77 and read together: valid_o=0, count_o=1.
- Flush/reset mid-stream: with 3 entries and overflow_o=1, assert flush together with insert 0x99.
  - Next cycle: count_o=0, overflow_o=0, empty_o=1; a subsequent read gives valid_o=0.
  - Repeat using rst instead of flush: same result.
